german_system: RTL and testbench



---
 rtl/german_system.sv | 227 ++++++++++++++++++++++
 tb/tb_german_system.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/german_system.sv
// german_system: three-node German cache-coherence protocol engine.
// One protocol rule may fire per clock, selected by io_en_a. A rule whose
// guard is false leaves every register untouched. All protocol state lives
// in named registers so it can be observed and poked from outside.
module german_system (
    input  logic       clock,
    input  logic       reset,
    input  logic [4:0] io_en_a
);

    typedef enum logic [1:0] {CACHE_I = 2'd0, CACHE_S = 2'd1, CACHE_E = 2'd2} cache_state_t;

    typedef enum logic [2:0] {
        CMD_EMPTY  = 3'd0, CMD_REQS = 3'd1, CMD_REQE = 3'd2, CMD_INV = 3'd3,
        CMD_INVACK = 3'd4, CMD_GNTS = 3'd5, CMD_GNTE = 3'd6
    } cmd_t;

    typedef enum logic [3:0] {
        R_STORE, R_SEND_REQ_S, R_SEND_REQ_E, R_RECV_REQ_S, R_RECV_REQ_E, R_SEND_INV,
        R_SEND_INV_ACK, R_RECV_INV_ACK, R_SEND_GNT_S, R_SEND_GNT_E, R_RECV_GNT_S, R_RECV_GNT_E
    } rule_t;

    // Protocol state registers, one set per node
    logic [1:0] Cache_reg_0_State, Cache_reg_1_State, Cache_reg_2_State;
    logic [1:0] Cache_reg_0_Data,  Cache_reg_1_Data,  Cache_reg_2_Data;
    logic [2:0] Chan1_reg_0_Cmd,   Chan1_reg_1_Cmd,   Chan1_reg_2_Cmd;
    logic [1:0] Chan1_reg_0_Data,  Chan1_reg_1_Data,  Chan1_reg_2_Data;
    logic [2:0] Chan2_reg_0_Cmd,   Chan2_reg_1_Cmd,   Chan2_reg_2_Cmd;
    logic [1:0] Chan2_reg_0_Data,  Chan2_reg_1_Data,  Chan2_reg_2_Data;
    logic [2:0] Chan3_reg_0_Cmd,   Chan3_reg_1_Cmd,   Chan3_reg_2_Cmd;
    logic [1:0] Chan3_reg_0_Data,  Chan3_reg_1_Data,  Chan3_reg_2_Data;
    logic       InvSet_reg_0, InvSet_reg_1, InvSet_reg_2;
    logic       ShrSet_reg_0, ShrSet_reg_1, ShrSet_reg_2;
    logic       ExGntd_reg;
    logic [2:0] CurCmd_reg;
    logic [1:0] CurPtr_reg;
    logic [1:0] MemData_reg;
    logic [1:0] AuxData_reg;

    // Array views of the current state and the computed next state
    logic [1:0] cs [3];
    logic [1:0] cd [3];
    logic [2:0] c1c [3];
    logic [1:0] c1d [3];
    logic [2:0] c2c [3];
    logic [1:0] c2d [3];
    logic [2:0] c3c [3];
    logic [1:0] c3d [3];
    logic [2:0] inv_set, shr_set;

    logic [1:0] cs_n [3];
    logic [1:0] cd_n [3];
    logic [2:0] c1c_n [3];
    logic [2:0] c2c_n [3];
    logic [1:0] c2d_n [3];
    logic [2:0] c3c_n [3];
    logic [1:0] c3d_n [3];
    logic [2:0] inv_set_n, shr_set_n;
    logic       exgntd_n;
    logic [2:0] cur_cmd_n;
    logic [1:0] cur_ptr_n;
    logic [1:0] mem_data_n;
    logic [1:0] aux_data_n;

    rule_t      kind;
    logic [1:0] nd;

    // Gather the named registers into per-node arrays
    always_comb begin
        cs  = '{Cache_reg_0_State, Cache_reg_1_State, Cache_reg_2_State};
        cd  = '{Cache_reg_0_Data,  Cache_reg_1_Data,  Cache_reg_2_Data};
        c1c = '{Chan1_reg_0_Cmd,   Chan1_reg_1_Cmd,   Chan1_reg_2_Cmd};
        c1d = '{Chan1_reg_0_Data,  Chan1_reg_1_Data,  Chan1_reg_2_Data};
        c2c = '{Chan2_reg_0_Cmd,   Chan2_reg_1_Cmd,   Chan2_reg_2_Cmd};
        c2d = '{Chan2_reg_0_Data,  Chan2_reg_1_Data,  Chan2_reg_2_Data};
        c3c = '{Chan3_reg_0_Cmd,   Chan3_reg_1_Cmd,   Chan3_reg_2_Cmd};
        c3d = '{Chan3_reg_0_Data,  Chan3_reg_1_Data,  Chan3_reg_2_Data};
        inv_set = {InvSet_reg_2, InvSet_reg_1, InvSet_reg_0};
        shr_set = {ShrSet_reg_2, ShrSet_reg_1, ShrSet_reg_0};
    end

    // Split the rule code into a rule kind and the node it acts on
    always_comb begin
        kind = R_STORE;
        nd   = 2'd0;
        if (io_en_a < 5'd24) begin
            kind = rule_t'(4'(io_en_a / 5'd3));
            nd   = 2'(io_en_a % 5'd3);
        end else if (io_en_a == 5'd24) begin
            kind = R_SEND_GNT_S;
        end else if (io_en_a == 5'd25) begin
            kind = R_SEND_GNT_E;
        end else if (io_en_a < 5'd29) begin
            kind = R_RECV_GNT_S;
            nd   = 2'(io_en_a - 5'd26);
        end else begin
            kind = R_RECV_GNT_E;
            nd   = 2'(io_en_a - 5'd29);
        end
    end

    // Evaluate the selected rule's guard and build the next state
    always_comb begin
        cs_n = cs; cd_n = cd; c1c_n = c1c; c2c_n = c2c; c2d_n = c2d;
        c3c_n = c3c; c3d_n = c3d;
        inv_set_n  = inv_set;
        shr_set_n  = shr_set;
        exgntd_n   = ExGntd_reg;
        cur_cmd_n  = CurCmd_reg;
        cur_ptr_n  = CurPtr_reg;
        mem_data_n = MemData_reg;
        aux_data_n = AuxData_reg;
        unique case (kind)
            R_STORE: if (cs[nd] == CACHE_E) begin
                cd_n[nd]   = (AuxData_reg == 2'd1) ? 2'd2 : 2'd1;
                aux_data_n = (AuxData_reg == 2'd1) ? 2'd2 : 2'd1;
            end
            R_SEND_REQ_S: if (c1c[nd] == CMD_EMPTY && cs[nd] == CACHE_I)
                c1c_n[nd] = CMD_REQS;
            R_SEND_REQ_E: if (c1c[nd] == CMD_EMPTY && (cs[nd] == CACHE_I || cs[nd] == CACHE_S))
                c1c_n[nd] = CMD_REQE;
            R_RECV_REQ_S, R_RECV_REQ_E:
                if (CurCmd_reg == CMD_EMPTY &&
                    c1c[nd] == ((kind == R_RECV_REQ_S) ? CMD_REQS : CMD_REQE)) begin
                    cur_cmd_n = c1c[nd];
                    cur_ptr_n = nd;
                    c1c_n[nd] = CMD_EMPTY;
                    inv_set_n = shr_set;
                end
            R_SEND_INV: if (c2c[nd] == CMD_EMPTY && inv_set[nd] &&
                            (CurCmd_reg == CMD_REQE || (CurCmd_reg == CMD_REQS && ExGntd_reg))) begin
                c2c_n[nd]     = CMD_INV;
                inv_set_n[nd] = 1'b0;
            end
            R_SEND_INV_ACK: if (c2c[nd] == CMD_INV && c3c[nd] == CMD_EMPTY) begin
                c2c_n[nd] = CMD_EMPTY;
                c3c_n[nd] = CMD_INVACK;
                if (cs[nd] == CACHE_E) c3d_n[nd] = cd[nd];
                cs_n[nd] = CACHE_I;
                cd_n[nd] = 2'd0;
            end
            R_RECV_INV_ACK: if (c3c[nd] == CMD_INVACK && CurCmd_reg != CMD_EMPTY) begin
                c3c_n[nd]     = CMD_EMPTY;
                c3d_n[nd]     = 2'd0;
                shr_set_n[nd] = 1'b0;
                if (ExGntd_reg) begin
                    exgntd_n   = 1'b0;
                    mem_data_n = c3d[nd];
                end
            end
            R_SEND_GNT_S, R_SEND_GNT_E:
                if (CurPtr_reg < 2'd3 && !ExGntd_reg && c2c[CurPtr_reg] == CMD_EMPTY &&
                    ((kind == R_SEND_GNT_S && CurCmd_reg == CMD_REQS) ||
                     (kind == R_SEND_GNT_E && CurCmd_reg == CMD_REQE && shr_set == 3'b000))) begin
                    c2c_n[CurPtr_reg]     = (kind == R_SEND_GNT_S) ? CMD_GNTS : CMD_GNTE;
                    c2d_n[CurPtr_reg]     = MemData_reg;
                    shr_set_n[CurPtr_reg] = 1'b1;
                    cur_cmd_n             = CMD_EMPTY;
                    if (kind == R_SEND_GNT_E) exgntd_n = 1'b1;
                end
            R_RECV_GNT_S, R_RECV_GNT_E:
                if (c2c[nd] == ((kind == R_RECV_GNT_S) ? CMD_GNTS : CMD_GNTE)) begin
                    cs_n[nd]  = (kind == R_RECV_GNT_S) ? CACHE_S : CACHE_E;
                    cd_n[nd]  = c2d[nd];
                    c2c_n[nd] = CMD_EMPTY;
                    c2d_n[nd] = 2'd0;
                end
            default: ;
        endcase
    end

    // State register: reset loads the initial state, otherwise take the rule result
    always_ff @(posedge clock) begin
        if (reset) begin
            {Cache_reg_0_State, Cache_reg_1_State, Cache_reg_2_State} <= '0;
            {Cache_reg_0_Data,  Cache_reg_1_Data,  Cache_reg_2_Data}  <= '0;
            {Chan1_reg_0_Cmd,   Chan1_reg_1_Cmd,   Chan1_reg_2_Cmd}   <= '0;
            {Chan1_reg_0_Data,  Chan1_reg_1_Data,  Chan1_reg_2_Data}  <= '0;
            {Chan2_reg_0_Cmd,   Chan2_reg_1_Cmd,   Chan2_reg_2_Cmd}   <= '0;
            {Chan2_reg_0_Data,  Chan2_reg_1_Data,  Chan2_reg_2_Data}  <= '0;
            {Chan3_reg_0_Cmd,   Chan3_reg_1_Cmd,   Chan3_reg_2_Cmd}   <= '0;
            {Chan3_reg_0_Data,  Chan3_reg_1_Data,  Chan3_reg_2_Data}  <= '0;
            {InvSet_reg_2, InvSet_reg_1, InvSet_reg_0} <= 3'b000;
            {ShrSet_reg_2, ShrSet_reg_1, ShrSet_reg_0} <= 3'b000;
            ExGntd_reg  <= 1'b0;
            CurCmd_reg  <= CMD_EMPTY;
            CurPtr_reg  <= 2'd0;
            MemData_reg <= 2'd1;
            AuxData_reg <= 2'd1;
        end else begin
            {Cache_reg_0_State, Cache_reg_1_State, Cache_reg_2_State} <= {cs_n[0], cs_n[1], cs_n[2]};
            {Cache_reg_0_Data,  Cache_reg_1_Data,  Cache_reg_2_Data}  <= {cd_n[0], cd_n[1], cd_n[2]};
            {Chan1_reg_0_Cmd,   Chan1_reg_1_Cmd,   Chan1_reg_2_Cmd}   <= {c1c_n[0], c1c_n[1], c1c_n[2]};
            {Chan1_reg_0_Data,  Chan1_reg_1_Data,  Chan1_reg_2_Data}  <= {c1d[0], c1d[1], c1d[2]};
            {Chan2_reg_0_Cmd,   Chan2_reg_1_Cmd,   Chan2_reg_2_Cmd}   <= {c2c_n[0], c2c_n[1], c2c_n[2]};
            {Chan2_reg_0_Data,  Chan2_reg_1_Data,  Chan2_reg_2_Data}  <= {c2d_n[0], c2d_n[1], c2d_n[2]};
            {Chan3_reg_0_Cmd,   Chan3_reg_1_Cmd,   Chan3_reg_2_Cmd}   <= {c3c_n[0], c3c_n[1], c3c_n[2]};
            {Chan3_reg_0_Data,  Chan3_reg_1_Data,  Chan3_reg_2_Data}  <= {c3d_n[0], c3d_n[1], c3d_n[2]};
            {InvSet_reg_2, InvSet_reg_1, InvSet_reg_0} <= inv_set_n;
            {ShrSet_reg_2, ShrSet_reg_1, ShrSet_reg_0} <= shr_set_n;
            ExGntd_reg  <= exgntd_n;
            CurCmd_reg  <= cur_cmd_n;
            CurPtr_reg  <= cur_ptr_n;
            MemData_reg <= mem_data_n;
            AuxData_reg <= aux_data_n;
        end
    end

    logic [2:0] is_e, is_s;
    logic       excl_ok, data_ok;

    // Coherence invariants over the current state
    always_comb begin
        data_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            is_e[i] = (cs[i] == CACHE_E);
            is_s[i] = (cs[i] == CACHE_S);
            if ((is_e[i] || is_s[i]) && cd[i] != AuxData_reg) data_ok = 1'b0;
        end
        excl_ok = $onehot0(is_e) && (is_e == 3'b000 || is_s == 3'b000);
    end

    a_exclusive: assert property (@(posedge clock) disable iff (reset) excl_ok);
    a_mem_data:  assert property (@(posedge clock) disable iff (reset) (ExGntd_reg || MemData_reg == AuxData_reg));
    a_cache_data: assert property (@(posedge clock) disable iff (reset) data_ok);

endmodule

// File: tb/tb_german_system.sv
// tb_german_system: directed walk through the German protocol with
// hand-computed register expectations after each rule.
module tb_german_system;

    logic       clock;
    logic       reset;
    logic [4:0] io_en_a;

    int checks = 0;
    int errors = 0;

    german_system dut (
        .clock   (clock),
        .reset   (reset),
        .io_en_a (io_en_a)
    );

    // Free-running clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one rule code (and reset level) for exactly one rising edge
    task automatic applyStimulus(input logic [4:0] code, input logic rst);
        io_en_a = code;
        reset   = rst;
        @(posedge clock);
        #1;
    endtask

    // Compare one observed register against its expected value
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Directed protocol sequence
    initial begin
        reset   = 1'b1;
        io_en_a = 5'd4;
        applyStimulus(5'd4, 1'b1);
        applyStimulus(5'd4, 1'b1);
        checkOutput("rst_cache0_state", int'(dut.Cache_reg_0_State), 0);
        checkOutput("rst_cache2_data",  int'(dut.Cache_reg_2_Data), 0);
        checkOutput("rst_chan1_1_cmd",  int'(dut.Chan1_reg_1_Cmd), 0);
        checkOutput("rst_chan2_1_cmd",  int'(dut.Chan2_reg_1_Cmd), 0);
        checkOutput("rst_chan3_2_cmd",  int'(dut.Chan3_reg_2_Cmd), 0);
        checkOutput("rst_invset1",      int'(dut.InvSet_reg_1), 0);
        checkOutput("rst_shrset2",      int'(dut.ShrSet_reg_2), 0);
        checkOutput("rst_exgntd",       int'(dut.ExGntd_reg), 0);
        checkOutput("rst_curcmd",       int'(dut.CurCmd_reg), 0);
        checkOutput("rst_curptr",       int'(dut.CurPtr_reg), 0);
        checkOutput("rst_memdata",      int'(dut.MemData_reg), 1);
        checkOutput("rst_auxdata",      int'(dut.AuxData_reg), 1);

        applyStimulus(5'd6, 1'b0);
        checkOutput("reqe0_chan1_cmd", int'(dut.Chan1_reg_0_Cmd), 2);
        applyStimulus(5'd12, 1'b0);
        checkOutput("recvreqe0_curcmd", int'(dut.CurCmd_reg), 2);
        checkOutput("recvreqe0_chan1", int'(dut.Chan1_reg_0_Cmd), 0);
        applyStimulus(5'd25, 1'b0);
        checkOutput("gnte_chan2_cmd",  int'(dut.Chan2_reg_0_Cmd), 6);
        checkOutput("gnte_chan2_data", int'(dut.Chan2_reg_0_Data), 1);
        applyStimulus(5'd29, 1'b0);
        checkOutput("own_cache0_state", int'(dut.Cache_reg_0_State), 2);
        checkOutput("own_cache0_data",  int'(dut.Cache_reg_0_Data), 1);
        checkOutput("own_exgntd",       int'(dut.ExGntd_reg), 1);
        checkOutput("own_shrset0",      int'(dut.ShrSet_reg_0), 1);
        checkOutput("own_curcmd",       int'(dut.CurCmd_reg), 0);
        checkOutput("own_chan2_cmd",    int'(dut.Chan2_reg_0_Cmd), 0);

        applyStimulus(5'd25, 1'b0);
        checkOutput("g25_chan2_cmd", int'(dut.Chan2_reg_0_Cmd), 0);
        checkOutput("g25_exgntd",    int'(dut.ExGntd_reg), 1);
        checkOutput("g25_curcmd",    int'(dut.CurCmd_reg), 0);
        applyStimulus(5'd1, 1'b0);
        checkOutput("g1_cache1_data", int'(dut.Cache_reg_1_Data), 0);
        checkOutput("g1_auxdata",     int'(dut.AuxData_reg), 1);

        applyStimulus(5'd0, 1'b0);
        checkOutput("st1_cache0_data", int'(dut.Cache_reg_0_Data), 2);
        checkOutput("st1_auxdata",     int'(dut.AuxData_reg), 2);
        checkOutput("st1_memdata",     int'(dut.MemData_reg), 1);
        applyStimulus(5'd0, 1'b0);
        checkOutput("st2_cache0_data", int'(dut.Cache_reg_0_Data), 1);
        checkOutput("st2_auxdata",     int'(dut.AuxData_reg), 1);
        applyStimulus(5'd0, 1'b0);
        checkOutput("st3_cache0_data", int'(dut.Cache_reg_0_Data), 2);

        applyStimulus(5'd4, 1'b0);
        checkOutput("reqs1_chan1_cmd", int'(dut.Chan1_reg_1_Cmd), 1);
        applyStimulus(5'd10, 1'b0);
        checkOutput("recvreqs1_invset0", int'(dut.InvSet_reg_0), 1);
        checkOutput("recvreqs1_invset1", int'(dut.InvSet_reg_1), 0);
        checkOutput("recvreqs1_curcmd",  int'(dut.CurCmd_reg), 1);
        checkOutput("recvreqs1_curptr",  int'(dut.CurPtr_reg), 1);
        applyStimulus(5'd15, 1'b0);
        checkOutput("inv0_chan2_cmd", int'(dut.Chan2_reg_0_Cmd), 3);
        checkOutput("inv0_invset0",   int'(dut.InvSet_reg_0), 0);
        applyStimulus(5'd18, 1'b0);
        checkOutput("ack0_chan3_cmd",     int'(dut.Chan3_reg_0_Cmd), 4);
        checkOutput("ack0_chan3_data",    int'(dut.Chan3_reg_0_Data), 2);
        checkOutput("ack0_cache0_state",  int'(dut.Cache_reg_0_State), 0);
        checkOutput("ack0_cache0_data",   int'(dut.Cache_reg_0_Data), 0);
        checkOutput("ack0_chan2_cmd",     int'(dut.Chan2_reg_0_Cmd), 0);
        applyStimulus(5'd21, 1'b0);
        checkOutput("rack0_memdata",   int'(dut.MemData_reg), 2);
        checkOutput("rack0_exgntd",    int'(dut.ExGntd_reg), 0);
        checkOutput("rack0_chan3_cmd", int'(dut.Chan3_reg_0_Cmd), 0);
        checkOutput("rack0_chan3_data", int'(dut.Chan3_reg_0_Data), 0);
        checkOutput("rack0_shrset0",   int'(dut.ShrSet_reg_0), 0);
        applyStimulus(5'd24, 1'b0);
        checkOutput("gnts_chan2_1_cmd",  int'(dut.Chan2_reg_1_Cmd), 5);
        checkOutput("gnts_chan2_1_data", int'(dut.Chan2_reg_1_Data), 2);
        checkOutput("gnts_curcmd",       int'(dut.CurCmd_reg), 0);
        applyStimulus(5'd27, 1'b0);
        checkOutput("share1_cache1_state", int'(dut.Cache_reg_1_State), 1);
        checkOutput("share1_cache1_data",  int'(dut.Cache_reg_1_Data), 2);
        checkOutput("share1_shrset1",      int'(dut.ShrSet_reg_1), 1);
        checkOutput("share1_chan2_1_cmd",  int'(dut.Chan2_reg_1_Cmd), 0);

        applyStimulus(5'd5, 1'b0);
        applyStimulus(5'd11, 1'b0);
        checkOutput("recvreqs2_curcmd",  int'(dut.CurCmd_reg), 1);
        checkOutput("recvreqs2_curptr",  int'(dut.CurPtr_reg), 2);
        checkOutput("recvreqs2_invset1", int'(dut.InvSet_reg_1), 1);
        force dut.CurPtr_reg = 2'd3;
        applyStimulus(5'd24, 1'b0);
        checkOutput("g24_curcmd",       int'(dut.CurCmd_reg), 1);
        checkOutput("g24_chan2_2_cmd",  int'(dut.Chan2_reg_2_Cmd), 0);
        checkOutput("g24_chan2_0_cmd",  int'(dut.Chan2_reg_0_Cmd), 0);
        checkOutput("g24_shrset2",      int'(dut.ShrSet_reg_2), 0);
        release dut.CurPtr_reg;

        applyStimulus(5'd0, 1'b1);
        checkOutput("rst2_curptr",       int'(dut.CurPtr_reg), 0);
        checkOutput("rst2_cache1_state", int'(dut.Cache_reg_1_State), 0);
        applyStimulus(5'd6, 1'b0);
        applyStimulus(5'd12, 1'b0);
        checkOutput("mid_curcmd", int'(dut.CurCmd_reg), 2);
        applyStimulus(5'd25, 1'b1);
        checkOutput("midrst_curcmd",    int'(dut.CurCmd_reg), 0);
        checkOutput("midrst_chan1_0",   int'(dut.Chan1_reg_0_Cmd), 0);
        checkOutput("midrst_chan2_0",   int'(dut.Chan2_reg_0_Cmd), 0);
        checkOutput("midrst_exgntd",    int'(dut.ExGntd_reg), 0);

        reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
